mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency unified memory between the instruction fetch port (read-only, word-aligned fetch of 32-bit or compressed 16-bit instructions) and the data memory port (load/store). The block sits between the fetch and mem stages and the memory macro. It sequences one transaction at a time, with back-to-back issue allowed. Data port has priority, with a starvation guard for fetch. A pipeline flush cancels the outstanding fetch response.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter_starve_counter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data unified memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_MAX_LATENCY = 4;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = 4;
    localparam int unsigned LAT_W           = $clog2(ARB_MAX_LATENCY + 1);

    typedef enum logic {OWN_IF, OWN_DM} arb_owner_type;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_type;

    // Command presented to the memory macro on an issue cycle
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-macro signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [BE_W-1:0]   dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters plus memory macro
    modport master (
        output if_req, if_addr, if_flush,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive fetch arbitration losses; sat flags the limit.
module mem_port_arbiter_starve_counter #(
    parameter int unsigned MAX_STARVE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; increment stops at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(MAX_STARVE))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sat   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat   <= (cnt_d == CNT_W'(MAX_STARVE));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data
// ports: data has priority, fetch wins after MAX_STARVE consecutive losses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned MAX_STARVE = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_type    state_q;
    arb_state_type    state_d;
    arb_owner_type    owner_q;
    arb_owner_type    owner_d;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] lat_d;
    logic             kill_q;
    logic             kill_d;

    logic             resp;
    logic             issue_ok;
    logic             pick_if;
    logic             pick_dm;
    logic             starve_sat;
    logic             starve_inc;
    logic             starve_clr;

    logic             if_gnt_c;
    logic             dm_gnt_c;
    logic             if_rvalid_c;
    logic             dm_rvalid_c;
    mem_cmd_t         cmd_c;

    assign resp     = (state_q == ARB_BUSY) && (lat_q == LAT_W'(LATENCY));
    assign issue_ok = (state_q == ARB_IDLE) || resp;
    assign pick_if  = bus.if_req && (!bus.dm_req || starve_sat);
    assign pick_dm  = bus.dm_req && !pick_if;

    // Next state, response steering and issue mux
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        kill_d      = kill_q;
        if_gnt_c    = 1'b0;
        dm_gnt_c    = 1'b0;
        if_rvalid_c = 1'b0;
        dm_rvalid_c = 1'b0;
        cmd_c       = '0;

        case (state_q)
            ARB_BUSY: begin
                if (resp) begin
                    // A flush arriving on the response cycle still kills it
                    if_rvalid_c = (owner_q == OWN_IF) && !kill_q && !bus.if_flush;
                    dm_rvalid_c = (owner_q == OWN_DM);
                    state_d     = ARB_IDLE;
                    lat_d       = '0;
                    kill_d      = 1'b0;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                    if ((owner_q == OWN_IF) && bus.if_flush) begin
                        kill_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        if (issue_ok && (pick_if || pick_dm)) begin
            state_d = ARB_BUSY;
            lat_d   = LAT_W'(1);
            if (pick_if) begin
                if_gnt_c    = 1'b1;
                owner_d     = OWN_IF;
                cmd_c.we    = 1'b0;
                cmd_c.be    = '1;
                cmd_c.addr  = word_addr(bus.if_addr);
                cmd_c.wdata = '0;
            end else begin
                dm_gnt_c    = 1'b1;
                owner_d     = OWN_DM;
                cmd_c.we    = bus.dm_we;
                cmd_c.be    = bus.dm_be;
                cmd_c.addr  = word_addr(bus.dm_addr);
                cmd_c.wdata = bus.dm_wdata;
            end
        end

        if (reset) begin
            if_gnt_c    = 1'b0;
            dm_gnt_c    = 1'b0;
            if_rvalid_c = 1'b0;
            dm_rvalid_c = 1'b0;
            cmd_c       = '0;
        end
    end

    assign starve_clr = if_gnt_c || !bus.if_req;
    assign starve_inc = issue_ok && bus.if_req && dm_gnt_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
            lat_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            kill_q  <= kill_d;
        end
    end

    mem_port_arbiter_starve_counter #(
        .MAX_STARVE (MAX_STARVE)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

    assign bus.if_gnt    = if_gnt_c;
    assign bus.dm_gnt    = dm_gnt_c;
    assign bus.if_rvalid = if_rvalid_c;
    assign bus.dm_rvalid = dm_rvalid_c;
    assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = dm_rvalid_c ? bus.mem_rdata : '0;
    assign bus.mem_en    = if_gnt_c || dm_gnt_c;
    assign bus.mem_we    = cmd_c.we;
    assign bus.mem_be    = cmd_c.be;
    assign bus.mem_addr  = cmd_c.addr;
    assign bus.mem_wdata = cmd_c.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance per LATENCY 1..4, scoreboarded responses.
module tb_mem_port_arbiter;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        bit          chk_data;
        int          due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          sel;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    rsp_t        sb[$];

    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_be;

    logic        if_gnt_a [4], dm_gnt_a [4], if_rvalid_a [4], dm_rvalid_a [4];
    logic        mem_en_a [4], mem_we_a [4];
    logic [3:0]  mem_be_a [4];
    logic [31:0] if_rdata_a [4], dm_rdata_a [4], mem_addr_a [4], mem_wdata_a [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEB;
    endfunction

    function automatic logic [31:0] waddr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_inst
        mem_port_arbiter_if bus();
        logic [32:0] pipe [g+1];

        assign bus.if_req   = (sel == g) ? if_req : 1'b0;
        assign bus.dm_req   = (sel == g) ? dm_req : 1'b0;
        assign bus.if_flush = (sel == g) ? if_flush : 1'b0;
        assign bus.if_addr  = if_addr;
        assign bus.dm_we    = dm_we;
        assign bus.dm_be    = dm_be;
        assign bus.dm_addr  = dm_addr;
        assign bus.dm_wdata = dm_wdata;
        // Memory model: read data returns g+1 cycles after mem_en, junk otherwise
        assign bus.mem_rdata = pipe[g][32] ? pipe[g][31:0] : 32'h5A5A_5A5A;

        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i <= g; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= {bus.mem_en && !bus.mem_we, mem_fn(bus.mem_addr)};
                for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
            end
        end

        mem_port_arbiter #(.LATENCY(g + 1), .MAX_STARVE(3)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        assign if_gnt_a[g]    = bus.if_gnt;
        assign dm_gnt_a[g]    = bus.dm_gnt;
        assign if_rvalid_a[g] = bus.if_rvalid;
        assign dm_rvalid_a[g] = bus.dm_rvalid;
        assign if_rdata_a[g]  = bus.if_rdata;
        assign dm_rdata_a[g]  = bus.dm_rdata;
        assign mem_en_a[g]    = bus.mem_en;
        assign mem_we_a[g]    = bus.mem_we;
        assign mem_be_a[g]    = bus.mem_be;
        assign mem_addr_a[g]  = bus.mem_addr;
        assign mem_wdata_a[g] = bus.mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", tag, sel, cyc, got, exp);
    endtask

    function automatic logic [31:0] mem_or(input int k);
        return 32'(mem_en_a[k]) | 32'(mem_we_a[k]) | 32'(mem_be_a[k]) | mem_addr_a[k] | mem_wdata_a[k];
    endfunction

    function automatic logic [31:0] out_or(input int k);
        return mem_or(k) | 32'(if_gnt_a[k]) | 32'(dm_gnt_a[k]) | 32'(if_rvalid_a[k])
             | 32'(dm_rvalid_a[k]) | if_rdata_a[k] | dm_rdata_a[k];
    endfunction

    // Response monitor: every rvalid must match the oldest scoreboard entry
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++) begin
                logic        rv;
                logic [31:0] rd;
                rsp_t        e;
                rv = (p == 0) ? if_rvalid_a[k] : dm_rvalid_a[k];
                rd = (p == 0) ? if_rdata_a[k] : dm_rdata_a[k];
                if (rv) begin
                    if (sb.size() == 0) begin
                        check_eq("rvalid_extra", 32'(rv), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("rsp_inst", k, e.inst);
                        check_eq("rsp_port", p, e.port);
                        check_eq("rsp_cycle", cyc, e.due);
                        if (e.chk_data) check_eq("rsp_data", rd, e.data);
                    end
                end else if (k == sel) begin
                    check_eq("rdata_idle", rd, 32'd0);
                end
            end
        end
    end

    // One cycle: check grants and memory command, then queue the expected response
    task automatic step(input bit e_ig, input bit e_dg, input bit no_rsp);
        @(negedge clk);
        check_eq("if_gnt", 32'(if_gnt_a[sel]), 32'(e_ig));
        check_eq("dm_gnt", 32'(dm_gnt_a[sel]), 32'(e_dg));
        if (e_ig || e_dg) begin
            check_eq("mem_en", 32'(mem_en_a[sel]), 32'd1);
            check_eq("mem_addr", mem_addr_a[sel], e_ig ? waddr(if_addr) : waddr(dm_addr));
            check_eq("mem_we", 32'(mem_we_a[sel]), e_ig ? 32'd0 : 32'(dm_we));
            check_eq("mem_be", 32'(mem_be_a[sel]), e_ig ? 32'hF : 32'(dm_be));
            check_eq("mem_wdata", mem_wdata_a[sel], e_ig ? 32'd0 : dm_wdata);
            if (e_ig && !no_rsp) sb.push_back('{sel, 0, mem_fn(waddr(if_addr)), 1'b1, cyc + sel + 1});
            if (e_dg) sb.push_back('{sel, 1, mem_fn(waddr(dm_addr)), !dm_we, cyc + sel + 1});
        end else begin
            check_eq("mem_idle", mem_or(sel), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_flush = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) check_eq("rst_out", out_or(k), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
        step(0, 0, 0);
    endtask

    initial begin
        sel = 0; reset = 1'b1;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        do_reset();

        // Halfword-aligned fetch, LATENCY=2: data 0xDEADBEEF from word 0x4
        sel = 1;
        if_req = 1'b1; if_addr = 32'h0000_0006;
        step(1, 0, 0);
        if_req = 1'b0;
        repeat (3) step(0, 0, 0);

        // Starvation guard, LATENCY=1
        do_reset();
        sel = 0;
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_be = 4'h0;
        for (int i = 0; i < 8; i++) step(i % 4 == 3, i % 4 != 3, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        if_req = 1'b0;
        step(0, 1, 0);
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) step(i == 3, i != 3, 0);
        if_req = 1'b0; dm_req = 1'b0;
        step(0, 0, 0);

        // Byte store then load, LATENCY=3
        do_reset();
        sel = 2;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h103; dm_be = 4'b1000; dm_wdata = 32'hAA00_0000;
        step(0, 1, 0);
        dm_req = 1'b0;
        repeat (3) step(0, 0, 0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h204; dm_be = 4'h0; dm_wdata = '0;
        step(0, 1, 0);
        dm_req = 1'b0;
        repeat (3) step(0, 0, 0);

        // Flush after grant kills response; dm issues back-to-back on that slot
        if_req = 1'b1; if_addr = 32'h40;
        step(1, 0, 1);
        if_req = 1'b0; if_flush = 1'b1;
        step(0, 0, 0);
        if_flush = 1'b0;
        step(0, 0, 0);
        dm_req = 1'b1; dm_addr = 32'h80;
        step(0, 1, 0);
        dm_req = 1'b0;
        repeat (3) step(0, 0, 0);
        // Flush in the grant cycle itself does not kill
        if_req = 1'b1; if_addr = 32'h44; if_flush = 1'b1;
        step(1, 0, 0);
        if_req = 1'b0; if_flush = 1'b0;
        repeat (3) step(0, 0, 0);
        // Flush on the response cycle kills
        if_req = 1'b1; if_addr = 32'h48;
        step(1, 0, 1);
        if_req = 1'b0;
        repeat (2) step(0, 0, 0);
        if_flush = 1'b1;
        step(0, 0, 0);
        if_flush = 1'b0;
        step(0, 0, 0);
        // Flush during a data access has no effect on it
        dm_req = 1'b1; dm_addr = 32'h84;
        step(0, 1, 0);
        dm_req = 1'b0; if_flush = 1'b1;
        repeat (3) step(0, 0, 0);
        if_flush = 1'b0;
        step(0, 0, 0);

        // Alternating requesters, LATENCY=1: memory busy every cycle
        do_reset();
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                if_req = 1'b1; dm_req = 1'b0; if_addr = 32'h100 + 32'(4 * i);
                step(1, 0, 0);
            end else begin
                if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h300 + 32'(4 * i);
                step(0, 1, 0);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) step(0, 0, 0);

        // Reset while BUSY (LATENCY=4, lat_cnt=2): access abandoned
        do_reset();
        sel = 3;
        if_req = 1'b1; if_addr = 32'h8;
        step(1, 0, 1);
        if_req = 1'b0;
        step(0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_busy_out", out_or(3), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; if_req = 1'b1; if_addr = 32'hC;
        step(1, 0, 0);
        if_req = 1'b0;
        repeat (5) step(0, 0, 0);

        check_eq("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
